// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS subset core (lw, sw, R-type add/sub/and/or/slt,
// beq, addi, and optionally j) built around one shared memory port.
// Optional feature macro: MIPS_MULTICYCLE_J_EN adds the j instruction and its
// JUMP state; without it opcode 0x02 decodes as illegal.
module mips_multicycle #(
  parameter int PCW = 6,
  parameter int DW  = 32
) (
  input  logic           clk,
  input  logic           clr,
  output logic [PCW-1:0] mem_addr,
  input  logic [DW-1:0]  mem_rdata,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_we,
  output logic [PCW-1:0] pc,
  output logic [3:0]     state,
  output logic           retire,
  output logic           illegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    ADDIEX = 4'd8,
    ADDIWB = 4'd9,
    BRANCH = 4'd10
`ifdef MIPS_MULTICYCLE_J_EN
    , JUMP = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_MULTICYCLE_J_EN
  localparam logic [5:0] OP_J     = 6'h02;
`endif

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [DW-1:0]  ir_q, ir_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [DW-1:0]  aluOut_q, aluOut_d;
  logic [DW-1:0]  mdr_q, mdr_d;
  logic [DW-1:0]  rf_q [32];

  logic           rfWe;
  logic [4:0]     rfWaddr;
  logic [DW-1:0]  rfWdata;

  logic [5:0]     opcode;
  logic [4:0]     rs, rt, rd;
  logic [5:0]     funct;
  logic [15:0]    imm16;
  logic [DW-1:0]  immExt;
  logic [DW-1:0]  rsData, rtData;
  logic [DW-1:0]  aluResult;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign imm16  = ir_q[15:0];
  assign immExt = {{(DW-16){imm16[15]}}, imm16};

  // r0 is hardwired to zero on the read side; writes to it are dropped below
  assign rsData = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rtData = (rt == 5'd0) ? '0 : rf_q[rt];

  assign pc    = pc_q;
  assign state = state_q;

  // R-type ALU: unknown funct codes produce zero rather than trapping
  always_comb begin
    aluResult = '0;
    case (funct)
      FN_ADD:  aluResult = a_q + b_q;
      FN_SUB:  aluResult = a_q - b_q;
      FN_AND:  aluResult = a_q & b_q;
      FN_OR:   aluResult = a_q | b_q;
      FN_SLT:  aluResult = {{(DW-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: aluResult = '0;
    endcase
  end

  // Next-state, datapath register loads and per-state control outputs
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    aluOut_d  = aluOut_q;
    mdr_d     = mdr_q;
    mem_addr  = pc_q;
    mem_wdata = b_q;
    mem_we    = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;
    rfWe      = 1'b0;
    rfWaddr   = rt;
    rfWdata   = mdr_q;

    case (state_q)
      FETCH: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + PCW'(1);
        state_d = DECODE;
      end
      DECODE: begin
        a_d = rsData;
        b_d = rtData;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
`ifdef MIPS_MULTICYCLE_J_EN
          OP_J:         state_d = JUMP;
`endif
          default: begin
            illegal = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        aluOut_d = a_q + immExt;
        state_d  = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_addr = aluOut_q[PCW+1:2];
        mdr_d    = mem_rdata;
        state_d  = MEMWB;
      end
      MEMWB: begin
        rfWe    = 1'b1;
        rfWaddr = rt;
        rfWdata = mdr_q;
        retire  = 1'b1;
        state_d = FETCH;
      end
      MEMWR: begin
        mem_addr  = aluOut_q[PCW+1:2];
        mem_wdata = b_q;
        mem_we    = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      EXEC: begin
        aluOut_d = aluResult;
        state_d  = ALUWB;
      end
      ALUWB: begin
        rfWe    = 1'b1;
        rfWaddr = rd;
        rfWdata = aluOut_q;
        retire  = 1'b1;
        state_d = FETCH;
      end
      ADDIEX: begin
        aluOut_d = a_q + immExt;
        state_d  = ADDIWB;
      end
      ADDIWB: begin
        rfWe    = 1'b1;
        rfWaddr = rt;
        rfWdata = aluOut_q;
        retire  = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        // pc already points past the beq, so the offset is relative to pc+1
        if (a_q == b_q) begin
          pc_d = pc_q + imm16[PCW-1:0];
        end
        retire  = 1'b1;
        state_d = FETCH;
      end
`ifdef MIPS_MULTICYCLE_J_EN
      JUMP: begin
        pc_d    = ir_q[PCW-1:0];
        retire  = 1'b1;
        state_d = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase

    // Reset suppresses every side effect, even mid-writeback
    if (clr) begin
      mem_we  = 1'b0;
      retire  = 1'b0;
      illegal = 1'b0;
      rfWe    = 1'b0;
    end
  end

  // State and datapath registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluOut_q <= '0;
      mdr_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluOut_q <= aluOut_d;
      mdr_q    <= mdr_d;
    end
  end

  // Register file write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (rfWe && (rfWaddr != 5'd0)) begin
      rf_q[rfWaddr] <= rfWdata;
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed programs for mips_multicycle with a scoreboard of
// expected retirements (length, illegal flag, next pc) and expected stores.
module tb_mips_multicycle;

  typedef struct {
    int         len;
    logic       ill;
    logic [5:0] npc;
  } retire_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } store_t;

  logic        clk;
  logic        clr;
  logic [5:0]  memAddr;
  logic [31:0] memRdata;
  logic [31:0] memWdata;
  logic        memWe;
  logic [5:0]  pc;
  logic [3:0]  state;
  logic        retire;
  logic        illegal;

  logic [31:0] mem  [64];
  logic [31:0] prog [64];
  logic        loadEn;

  retire_t retQ[$];
  store_t  storeQ[$];

  int total;
  int bad;
  int cyc;
  int lastRetire;

  mips_multicycle #(.PCW(6), .DW(32)) dut (
    .clk       (clk),
    .clr       (clr),
    .mem_addr  (memAddr),
    .mem_rdata (memRdata),
    .mem_wdata (memWdata),
    .mem_we    (memWe),
    .pc        (pc),
    .state     (state),
    .retire    (retire),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unified memory: bulk program load from the bench, otherwise DUT stores
  always @(posedge clk) begin
    if (loadEn) begin
      for (int i = 0; i < 64; i++) mem[i] <= prog[i];
    end else if (memWe) begin
      mem[memAddr] <= memWdata;
    end
  end

  assign memRdata = mem[memAddr];

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clearProg();
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
  endtask

  task automatic expectRetire(input int len, input logic ill, input logic [5:0] npc);
    retire_t r;
    r.len = len;
    r.ill = ill;
    r.npc = npc;
    retQ.push_back(r);
  endtask

  task automatic expectStore(input logic [5:0] addr, input logic [31:0] data);
    store_t s;
    s.addr = addr;
    s.data = data;
    storeQ.push_back(s);
  endtask

  // Hold clr for two edges (optionally loading prog), check reset outputs, release
  task automatic applyStimulus(input bit reload);
    @(negedge clk);
    clr    = 1'b1;
    loadEn = reload;
    @(negedge clk);
    loadEn = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_mem_we", 32'(memWe), 32'd0);
    checkOutput("rst_retire", 32'(retire), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
    clr = 1'b0;
    #1;
    cyc        = 1;
    lastRetire = 0;
    checkOutput("first_fetch_state", 32'(state), 32'd0);
    checkOutput("first_fetch_addr", 32'(memAddr), 32'd0);
  endtask

  // Advance cycle by cycle, popping scoreboard entries as the DUT retires/stores
  task automatic runProgram(input string name, input int budget);
    bit         pcPending;
    logic [5:0] expPc;
    retire_t    r;
    store_t     s;
    pcPending = 1'b0;
    expPc     = '0;
    while ((retQ.size() > 0 || storeQ.size() > 0 || pcPending) && cyc <= budget) begin
      if (pcPending) begin
        checkOutput({name, "_next_pc"}, 32'(pc), 32'(expPc));
        pcPending = 1'b0;
      end
      if (memWe) begin
        if (storeQ.size() == 0) begin
          checkOutput({name, "_unexpected_store"}, 32'(memWe), 32'd0);
        end else begin
          s = storeQ.pop_front();
          checkOutput({name, "_store_addr"}, 32'(memAddr), 32'(s.addr));
          checkOutput({name, "_store_data"}, memWdata, s.data);
        end
      end
      if (retire) begin
        if (retQ.size() == 0) begin
          checkOutput({name, "_unexpected_retire"}, 32'(retire), 32'd0);
        end else begin
          r = retQ.pop_front();
          checkOutput({name, "_instr_cycles"}, 32'(cyc - lastRetire), 32'(r.len));
          checkOutput({name, "_illegal"}, 32'(illegal), 32'(r.ill));
          expPc     = r.npc;
          pcPending = 1'b1;
        end
        lastRetire = cyc;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    checkOutput({name, "_pending_after_budget"}, 32'(retQ.size() + storeQ.size()), 32'd0);
    retQ.delete();
    storeQ.delete();
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    clr    = 1'b1;
    loadEn = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;

    // Program A: addi/addi/add/slt, dump registers, spin on beq
    clearProg();
    prog[0] = iType(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = iType(6'h08, 5'd0, 5'd2, 16'hFFFD);
    prog[2] = rType(5'd1, 5'd2, 5'd3, 6'h20);
    prog[3] = rType(5'd2, 5'd1, 5'd4, 6'h2A);
    prog[4] = iType(6'h2B, 5'd0, 5'd3, 16'd40);
    prog[5] = iType(6'h2B, 5'd0, 5'd4, 16'd44);
    prog[6] = iType(6'h2B, 5'd0, 5'd1, 16'd48);
    prog[7] = iType(6'h2B, 5'd0, 5'd2, 16'd52);
    prog[8] = iType(6'h04, 5'd0, 5'd0, 16'hFFFF);
    applyStimulus(1'b1);
    expectRetire(4, 1'b0, 6'd1);
    expectRetire(4, 1'b0, 6'd2);
    expectRetire(4, 1'b0, 6'd3);
    expectRetire(4, 1'b0, 6'd4);
    expectRetire(4, 1'b0, 6'd5);
    expectRetire(4, 1'b0, 6'd6);
    expectRetire(4, 1'b0, 6'd7);
    expectRetire(4, 1'b0, 6'd8);
    expectRetire(3, 1'b0, 6'd8);
    expectRetire(3, 1'b0, 6'd8);
    expectStore(6'd10, 32'd2);
    expectStore(6'd11, 32'd1);
    expectStore(6'd12, 32'd5);
    expectStore(6'd13, 32'hFFFF_FFFD);
    runProgram("progA", 100);

    // Program B: sw/lw round trip, r0 write, beq not taken, illegal opcode
    clearProg();
    prog[0]  = iType(6'h08, 5'd0, 5'd1, 16'h0010);
    prog[1]  = iType(6'h23, 5'd0, 5'd5, 16'd60);
    prog[2]  = iType(6'h04, 5'd0, 5'd0, 16'd3);
    prog[6]  = iType(6'h2B, 5'd1, 5'd5, 16'd4);
    prog[7]  = iType(6'h23, 5'd1, 5'd6, 16'd4);
    prog[8]  = iType(6'h2B, 5'd0, 5'd6, 16'd160);
    prog[9]  = iType(6'h08, 5'd0, 5'd0, 16'd7);
    prog[10] = iType(6'h2B, 5'd0, 5'd0, 16'd164);
    prog[11] = iType(6'h04, 5'd1, 5'd2, 16'd5);
    prog[12] = {6'h3F, 26'd0};
    prog[13] = iType(6'h04, 5'd0, 5'd0, 16'hFFFF);
    prog[15] = 32'hDEAD_BEEF;
    applyStimulus(1'b1);
    expectRetire(4, 1'b0, 6'd1);
    expectRetire(5, 1'b0, 6'd2);
    expectRetire(3, 1'b0, 6'd6);
    expectRetire(4, 1'b0, 6'd7);
    expectRetire(5, 1'b0, 6'd8);
    expectRetire(4, 1'b0, 6'd9);
    expectRetire(4, 1'b0, 6'd10);
    expectRetire(4, 1'b0, 6'd11);
    expectRetire(3, 1'b0, 6'd12);
    expectRetire(2, 1'b1, 6'd13);
    expectRetire(3, 1'b0, 6'd13);
    expectRetire(3, 1'b0, 6'd13);
    expectStore(6'd5, 32'hDEAD_BEEF);
    expectStore(6'd40, 32'hDEAD_BEEF);
    expectStore(6'd41, 32'd0);
    runProgram("progB", 100);

    // Program C: reset lands in ADDIWB, so r1 must keep its old value 0x10
    clearProg();
    prog[0] = iType(6'h08, 5'd0, 5'd1, 16'd99);
    applyStimulus(1'b1);
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    checkOutput("progC_state_addiwb", 32'(state), 32'd9);
    checkOutput("progC_retire_before_clr", 32'(retire), 32'd1);
    clr = 1'b1;
    #1;
    checkOutput("progC_retire_in_clr", 32'(retire), 32'd0);

    // Program D: reset lands in MEMWR, then rerun and dump r1
    clearProg();
    prog[0] = iType(6'h2B, 5'd0, 5'd1, 16'd168);
    prog[1] = iType(6'h04, 5'd0, 5'd0, 16'hFFFF);
    applyStimulus(1'b1);
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    checkOutput("progD_state_memwr", 32'(state), 32'd5);
    checkOutput("progD_we_before_clr", 32'(memWe), 32'd1);
    clr = 1'b1;
    #1;
    checkOutput("progD_we_in_clr", 32'(memWe), 32'd0);
    checkOutput("progD_retire_in_clr", 32'(retire), 32'd0);
    applyStimulus(1'b0);
    expectRetire(4, 1'b0, 6'd1);
    expectRetire(3, 1'b0, 6'd1);
    expectRetire(3, 1'b0, 6'd1);
    expectStore(6'd42, 32'h0000_0010);
    runProgram("progD", 60);

    // Program E: branch to 0x3E, j (or illegal) at 0x3E, pc wraps after 0x3F
    clearProg();
    prog[0]  = iType(6'h04, 5'd0, 5'd0, 16'h003D);
    prog[62] = {6'h02, 26'h3F};
    prog[63] = iType(6'h08, 5'd0, 5'd10, 16'd1);
    applyStimulus(1'b1);
    expectRetire(3, 1'b0, 6'h3E);
`ifdef MIPS_MULTICYCLE_J_EN
    expectRetire(3, 1'b0, 6'h3F);
`else
    expectRetire(2, 1'b1, 6'h3F);
`endif
    expectRetire(4, 1'b0, 6'h00);
    expectRetire(3, 1'b0, 6'h3E);
    runProgram("progE", 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle.md
MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

Interface
REQ-001 Parameter PCW, default 6, word-address width of the shared instruction/data memory and of the PC.
REQ-002 Parameter DW, default 32, datapath and register width; legal value 32 only.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 mem_addr  output  PCW  word address to unified memory.
REQ-006 mem_rdata  input  DW  memory read data, combinational from mem_addr within the same cycle.
REQ-007 mem_wdata  output  DW  memory write data.
REQ-008 mem_we  output  1  memory write strobe, sampled by memory on the rising clk edge.
REQ-009 pc  output  PCW  current program counter (word address).
REQ-010 state  output  4  current FSM state encoding, for debug.
REQ-011 retire  output  1  one-cycle pulse in the final cycle of every instruction.
REQ-012 illegal  output  1  one-cycle pulse in DECODE when the opcode is unsupported.

Function
REQ-013 Core SHALL be multicycle: one instruction at a time, no overlap, using a single shared memory port.
REQ-014 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP.
REQ-015 FETCH: mem_addr=pc; IR<=mem_rdata; pc<=pc+1, modulo 2^PCW; next state DECODE.
REQ-016 DECODE: A<=rf[rs] and B<=rf[rt]. Next state by opcode: lw/sw->MEMADR, R-type (0x00)->EXEC, beq (0x04)->BRANCH, addi (0x08)->ADDIEX, j (0x02)->JUMP; any other opcode->FETCH with illegal=1 and retire=1.
REQ-017 MEMADR: ALUOut<=A+signext(imm16); next state MEMRD for lw (0x23), MEMWR for sw (0x2B).
REQ-018 MEMRD: mem_addr=ALUOut[PCW+1:2]; MDR<=mem_rdata; next state MEMWB.
REQ-019 MEMWB: rf[rt]<=MDR; retire=1; next state FETCH. lw totals 5 cycles.
REQ-020 MEMWR: mem_addr=ALUOut[PCW+1:2], mem_wdata=B, mem_we=1; retire=1; next state FETCH. sw totals 4 cycles.
REQ-021 EXEC: ALUOut<=A op B by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed; result 1 or 0). Any other funct yields 0. Next state ALUWB.
REQ-022 ALUWB: rf[rd]<=ALUOut; retire=1; next state FETCH. R-type totals 4 cycles.
REQ-023 ADDIEX: ALUOut<=A+signext(imm16). ADDIWB: rf[rt]<=ALUOut; retire=1. addi totals 4 cycles.
REQ-024 BRANCH: if A==B, pc<=pc+imm16[PCW-1:0], where pc already holds the incremented value, modulo 2^PCW; retire=1; next state FETCH. beq totals 3 cycles.
REQ-025 JUMP: pc<=IR[PCW-1:0]; retire=1; next state FETCH. j totals 3 cycles.
REQ-026 Arithmetic SHALL be DW-bit two's complement with overflow discarded; no exceptions.
REQ-027 Register file SHALL hold 32 x DW entries; reads of r0 SHALL return 0; writes to r0 SHALL be discarded.
REQ-028 mem_we SHALL be 1 only in MEMWR; mem_addr=pc in all states other than MEMRD and MEMWR.
REQ-029 retire and illegal SHALL be combinational decodes of state and opcode, and low in all other cycles.

Reset
REQ-030 clr=1 at a rising edge SHALL set pc=0 and state=FETCH, and SHALL clear IR, A, B, ALUOut and MDR.
REQ-031 While clr=1: mem_we=0, retire=0, illegal=0; no register-file write commits, including reset asserted in MEMWB, ALUWB, ADDIWB or MEMWR.
REQ-032 Register-file contents SHALL NOT be cleared by clr.
REQ-033 First FETCH SHALL occur in the first cycle after clr deasserts.

Configuration
REQ-034 Macro MIPS_MULTICYCLE_J_EN. When defined: j decodes per REQ-016 and REQ-025. When undefined: opcode 0x02 is illegal per REQ-016, and the JUMP state and its logic are absent.

Verification
REQ-035 clr for 2 cycles -> pc=0, state=FETCH, mem_we=0; register file unchanged.
REQ-036 Memory holds addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> r3=2, r4=1, and retire pulses at cycles 4, 8, 12 and 16 after reset.
REQ-037 r1=0x10, r5=0xDEADBEEF; sw $5,4($1) then lw $6,4($1) -> mem_we for 1 cycle at word 5; r6=0xDEADBEEF; lw takes 5 cycles.
REQ-038 beq $0,$0,-1 at word 3 -> pc returns to 3 every 3 cycles. beq $1,$2 with r1!=r2 -> pc=4.
REQ-039 j 0x3F at pc=0x3E, then an instruction at 0x3F -> pc wraps to 0 after the next fetch. Without MIPS_MULTICYCLE_J_EN -> illegal=1 and pc=0x3F.
REQ-040 Opcode 0x3F -> illegal=1 and retire=1 in DECODE, and instruction takes 2 cycles. addi $0,$0,7 -> r0 still reads 0.
